// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared instruction/data memory port; round-robin by default.
// Define ARB_FIXED_PRIO_EN to give port 0 absolute priority on contested arbitration.
module mem_arbiter #(
    parameter int unsigned LAT = 2,
    parameter int unsigned CW  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] adr0_i,
    input  logic [31:0] adr1_i,
    input  logic [31:0] wd0_i,
    input  logic [31:0] wd1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [31:0] rd0_o,
    output logic [31:0] rd1_o,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rd_i,
    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [31:0]   mem_adr_q, mem_adr_d;
    logic [31:0]   mem_wd_q, mem_wd_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [31:0]   rd0_q, rd0_d;
    logic [31:0]   rd1_q, rd1_d;
    logic          any_req_c;
    logic          grant_c;
    logic          sel_we_c;

`ifndef ARB_FIXED_PRIO_EN
    logic          last_q, last_d;
`endif

    assign any_req_c = req0_i | req1_i;
    assign sel_we_c  = grant_c ? we1_i : we0_i;

    // Winner of the current IDLE sample; only meaningful when any_req_c is high.
`ifdef ARB_FIXED_PRIO_EN
    assign grant_c = ~req0_i;
`else
    assign grant_c = (req0_i && req1_i) ? ~last_q : req1_i;
`endif

    // State register; async reset also clears mem_we so an aborted write never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            mem_adr_q <= '0;
            mem_wd_q  <= '0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            mem_adr_q <= mem_adr_d;
            mem_wd_q  <= mem_wd_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    // Next-state: arbitration, transaction latch and latency countdown.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        mem_adr_d = mem_adr_q;
        mem_wd_d  = mem_wd_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    owner_d   = grant_c;
                    we_d      = sel_we_c;
                    mem_adr_d = grant_c ? adr1_i : adr0_i;
                    mem_wd_d  = grant_c ? wd1_i : wd0_i;
                    cnt_d     = CW'(LAT - 1);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    mem_adr_d = '0;
                    mem_wd_d  = '0;
                    state_d   = DONE;
`ifndef ARB_FIXED_PRIO_EN
                    last_d    = owner_q;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: mem_we is registered one cycle early so it lands exactly on the cnt == 0 cycle.
    always_comb begin
        busy_d   = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        mem_we_d = 1'b0;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        unique case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    busy_d   = 1'b1;
                    mem_we_d = sel_we_c && (LAT == 1);
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        ack1_d = 1'b1;
                        rd1_d  = mem_rd_i;
                    end else begin
                        ack0_d = 1'b1;
                        rd0_d  = mem_rd_i;
                    end
                end else begin
                    mem_we_d = we_q && (cnt_q == CW'(1));
                end
            end
            DONE:    busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    assign ack0_o    = ack0_q;
    assign ack1_o    = ack1_q;
    assign rd0_o     = rd0_q;
    assign rd1_o     = rd1_q;
    assign mem_adr_o = mem_adr_q;
    assign mem_wd_o  = mem_wd_q;
    assign mem_we_o  = mem_we_q;
    assign busy_o    = busy_q;
    assign owner_o   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on LAT=2 and LAT=1 instances plus a randomized run
// checked against a transaction-level model of arbitration, timing and memory contents.
module tb_mem_arbiter;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req0, req1, we0, we1;
    logic [31:0] adr0, adr1, wd0, wd1;
    logic        ack0, ack1, mem_we, busy, owner;
    logic [31:0] rd0, rd1, mem_adr, mem_wd, mem_rd;

    logic        b_req0, b_req1;
    logic [31:0] b_adr0, b_adr1;
    logic        b_ack0, b_ack1, b_mem_we, b_busy, b_owner;
    logic [31:0] b_rd0, b_rd1, b_mem_adr, b_mem_wd, b_mem_rd;

    logic [31:0] mem [0:63];
    int          n_chk = 0;
    int          n_fail = 0;

    assign mem_rd   = mem[mem_adr[7:2]];
    assign b_mem_rd = mem[b_mem_adr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_adr[7:2]] <= mem_wd;

    mem_arbiter #(.LAT(LAT), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .adr0_i(adr0), .adr1_i(adr1), .wd0_i(wd0), .wd1_i(wd1),
        .ack0_o(ack0), .ack1_o(ack1), .rd0_o(rd0), .rd1_o(rd1),
        .mem_adr_o(mem_adr), .mem_wd_o(mem_wd), .mem_we_o(mem_we), .mem_rd_i(mem_rd),
        .busy_o(busy), .owner_o(owner)
    );

    mem_arbiter #(.LAT(1), .CW(4)) dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req0_i(b_req0), .req1_i(b_req1), .we0_i(1'b0), .we1_i(1'b0),
        .adr0_i(b_adr0), .adr1_i(b_adr1), .wd0_i(32'h0), .wd1_i(32'h0),
        .ack0_o(b_ack0), .ack1_o(b_ack1), .rd0_o(b_rd0), .rd1_o(b_rd1),
        .mem_adr_o(b_mem_adr), .mem_wd_o(b_mem_wd), .mem_we_o(b_mem_we), .mem_rd_i(b_mem_rd),
        .busy_o(b_busy), .owner_o(b_owner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
        b_req0 = 0; b_req1 = 0; b_adr0 = '0; b_adr1 = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        step();
    endtask

    task automatic drive_port(input bit p, input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] d);
        if (p) begin req1 = r; we1 = w; adr1 = a; wd1 = d; end
        else   begin req0 = r; we0 = w; adr0 = a; wd0 = d; end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) step();
        n_chk++;
        if ({ack0, ack1, mem_we, busy, owner} !== 5'b0 || rd0 !== 32'h0 || rd1 !== 32'h0 ||
            mem_adr !== 32'h0 || mem_wd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl=%b rd0=%h rd1=%h adr=%h wd=%h required all zero",
                     {ack0, ack1, mem_we, busy, owner}, rd0, rd1, mem_adr, mem_wd);
        end
        rst_n = 1;
        repeat (2) step();
        n_chk++;
        if ({busy, b_busy, ack0, b_ack0, b_rd0, b_rd1} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b b_busy=%b b_rd0=%h b_rd1=%h required 0",
                     busy, b_busy, b_rd0, b_rd1);
        end
    endtask

    task automatic test_single_read();
        mem[4] <= 32'hDEADBEEF;
        req0 = 1; we0 = 0; adr0 = 32'h10;
        step();                                    // cycle 1
        n_chk++;
        if (mem_adr !== 32'h10 || busy !== 1'b1 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL read_c1: adr=%h busy=%b owner=%b required 10 1 0", mem_adr, busy, owner);
        end
        step();                                    // cycle 2
        n_chk++;
        if (mem_adr !== 32'h10 || ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_c2: adr=%h ack0=%b required 10 0", mem_adr, ack0);
        end
        step();                                    // cycle 3
        n_chk++;
        if (ack0 !== 1'b1 || rd0 !== 32'hDEADBEEF || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_c3: ack0=%b rd0=%h ack1=%b required 1 deadbeef 0", ack0, rd0, ack1);
        end
        req0 = 0;
        step();                                    // cycle 4
        n_chk++;
        if (busy !== 1'b0 || ack0 !== 1'b0 || mem_adr !== 32'h0) begin
            n_fail++;
            $display("FAIL read_c4: busy=%b ack0=%b adr=%h required 0 0 0", busy, ack0, mem_adr);
        end
    endtask

    task automatic test_write();
        int we_cnt = 0, we_cyc = -1, ack_cnt = 0, ack_cyc = -1;
        logic [31:0] wd_seen = '0;
        req1 = 1; we1 = 1; adr1 = 32'h20; wd1 = 32'h12345678;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (mem_we) begin we_cnt++; we_cyc = c; wd_seen = mem_wd; end
            if (ack1) begin ack_cnt++; ack_cyc = c; req1 = 0; we1 = 0; end
        end
        n_chk++;
        if (we_cnt !== 1 || we_cyc !== 2 || wd_seen !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_strobe: count=%0d cycle=%0d wd=%h required 1 2 12345678",
                     we_cnt, we_cyc, wd_seen);
        end
        n_chk++;
        if (ack_cnt !== 1 || ack_cyc !== 3) begin
            n_fail++;
            $display("FAIL write_ack: count=%0d cycle=%0d required 1 3", ack_cnt, ack_cyc);
        end
        req0 = 1; we0 = 0; adr0 = 32'h20;
        ack_cnt = 0;
        for (int c = 1; c <= 8 && ack_cnt == 0; c++) begin
            step();
            if (ack0) begin ack_cnt++; req0 = 0; end
        end
        n_chk++;
        if (ack_cnt !== 1 || rd0 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_readback: acks=%0d rd0=%h required 1 12345678", ack_cnt, rd0);
        end
        step();
    endtask

    task automatic test_contend();
        int order[$];
        int cycs[$];
        bit ok;
        apply_reset();
        req0 = 1; req1 = 1; adr0 = 32'h10; adr1 = 32'h20;
        for (int c = 1; c <= 40 && order.size() < 4; c++) begin
            step();
            if (ack0 && ack1) begin order.push_back(9); cycs.push_back(c); end
            else if (ack0)    begin order.push_back(0); cycs.push_back(c); end
            else if (ack1)    begin order.push_back(1); cycs.push_back(c); end
        end
        clear_inputs();
        repeat (4) step();
        ok = (order.size() == 4);
        for (int i = 0; i < order.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
            if (order[i] != 0) ok = 0;
`else
            if (order[i] != (i % 2)) ok = 0;
`endif
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL contend_order: got %p required alternating starting at port 0", order);
        end
        ok = (cycs.size() == 4) && (cycs[0] == int'(LAT) + 1);
        for (int i = 1; i < cycs.size(); i++) if (cycs[i] - cycs[i-1] != int'(LAT) + 2) ok = 0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL contend_spacing: ack cycles %p required 3,7,11,15", cycs);
        end
    endtask

    task automatic test_slow_requester();
        int extra = 0;
        req0 = 1; we0 = 0; adr0 = 32'h10;
        repeat (3) step();                         // cycle 3: ack
        n_chk++;
        if (ack0 !== 1'b1) begin
            n_fail++;
            $display("FAIL slow_first_ack: ack0=%b required 1", ack0);
        end
        step();                                    // cycle 4: req0 still high in IDLE
        step();                                    // cycle 5
        n_chk++;
        if (busy !== 1'b1 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_second_start: busy=%b owner=%b required 1 0", busy, owner);
        end
        repeat (2) step();                         // cycle 7
        n_chk++;
        if (ack0 !== 1'b1) begin
            n_fail++;
            $display("FAIL slow_second_ack: ack0=%b required 1", ack0);
        end
        req0 = 0;
        repeat (2) step();
        req0 = 1;
        repeat (3) step();
        n_chk++;
        if (ack0 !== 1'b1) begin
            n_fail++;
            $display("FAIL prompt_ack: ack0=%b required 1", ack0);
        end
        req0 = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (busy || ack0) extra++;
        end
        n_chk++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL prompt_no_retrigger: busy/ack cycles=%0d required 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int acks = 0;
        mem[12] <= 32'h11111111;
        step();
        req0 = 1; we0 = 1; adr0 = 32'h30; wd0 = 32'hA5A5A5A5;
        repeat (2) step();                         // cycle 2: write strobe cycle
        n_chk++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_we: mem_we=%b required 1", mem_we);
        end
        rst_n = 0;
        #1;
        n_chk++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_we_drop: mem_we=%b required 0", mem_we);
        end
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            if (ack0 || ack1) acks++;
        end
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (ack0 || ack1) acks++;
        end
        n_chk++;
        if (acks !== 0 || mem[12] !== 32'h11111111) begin
            n_fail++;
            $display("FAIL abort_effect: acks=%0d mem=%h required 0 11111111", acks, mem[12]);
        end
        n_chk++;
        if ({ack0, ack1, mem_we, busy, owner} !== 5'b0 || rd0 !== 32'h0 || rd1 !== 32'h0 ||
            mem_adr !== 32'h0 || mem_wd !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_idle: ctl=%b rd0=%h rd1=%h adr=%h required all zero",
                     {ack0, ack1, mem_we, busy, owner}, rd0, rd1, mem_adr);
        end
    endtask

    task automatic test_lat1();
        b_req0 = 1; b_adr0 = 32'h10;
        repeat (2) step();                         // cycle 2
        n_chk++;
        if (b_ack0 !== 1'b1 || b_rd0 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lat1_port0: ack0=%b rd0=%h required 1 deadbeef", b_ack0, b_rd0);
        end
        b_req0 = 0;
        step();
        b_req1 = 1; b_adr1 = 32'h20;
        step();                                    // cycle 1
        n_chk++;
        if (b_busy !== 1'b1 || b_owner !== 1'b1 || b_mem_adr !== 32'h20 || b_ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1_access: busy=%b owner=%b adr=%h ack1=%b required 1 1 20 0",
                     b_busy, b_owner, b_mem_adr, b_ack1);
        end
        step();                                    // cycle 2
        n_chk++;
        if (b_ack1 !== 1'b1 || b_rd1 !== 32'h12345678 || b_rd0 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lat1_port1: ack1=%b rd1=%h rd0=%h required 1 12345678 deadbeef",
                     b_ack1, b_rd1, b_rd0);
        end
        b_req1 = 0;
        step();
        n_chk++;
        if (b_ack1 !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1_idle: ack1=%b busy=%b required 0 0", b_ack1, b_busy);
        end
    endtask

    task automatic test_random();
        int          t_start;
        bit          t_port, t_we, in_acc, is_ack;
        logic [31:0] t_adr, t_wd, t_rd;
        bit          pend[2], cool[2], r_we[2];
        logic [31:0] r_adr[2], r_wd[2], rd_m[2];
        logic [31:0] ref_mem[64];
        logic [4:0]  exp_ctl;
        logic [31:0] exp_adr, exp_wd;
`ifndef ARB_FIXED_PRIO_EN
        bit          m_last = 1'b1;
`endif
        apply_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        t_start = -100; t_port = 0; t_we = 0; t_adr = '0; t_wd = '0; t_rd = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; cool[p] = 0; r_we[p] = 0; r_adr[p] = '0; r_wd[p] = '0; rd_m[p] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            // What the arbiter must show in this cycle, given the last granted transaction.
            in_acc = (c >= t_start + 1) && (c <= t_start + int'(LAT));
            is_ack = (c == t_start + int'(LAT) + 1);
            if (is_ack) rd_m[t_port] = t_rd;
            exp_ctl = {is_ack && !t_port, is_ack && t_port, t_we && (c == t_start + int'(LAT)),
                       in_acc || is_ack, (in_acc || is_ack) ? t_port : owner};
            exp_adr = in_acc ? t_adr : 32'h0;
            exp_wd  = in_acc ? t_wd : 32'h0;
            n_chk++;
            if ({ack0, ack1, mem_we, busy, owner} !== exp_ctl) begin
                n_fail++;
                $display("FAIL rand_ctl c=%0d: ack0,ack1,we,busy,owner=%b required %b",
                         c, {ack0, ack1, mem_we, busy, owner}, exp_ctl);
            end
            n_chk++;
            if (mem_adr !== exp_adr || mem_wd !== exp_wd) begin
                n_fail++;
                $display("FAIL rand_bus c=%0d: adr=%h wd=%h required %h %h",
                         c, mem_adr, mem_wd, exp_adr, exp_wd);
            end
            n_chk++;
            if (rd0 !== rd_m[0] || rd1 !== rd_m[1]) begin
                n_fail++;
                $display("FAIL rand_rd c=%0d: rd0=%h rd1=%h required %h %h",
                         c, rd0, rd1, rd_m[0], rd_m[1]);
            end
            // Requesters: drop on ack, rest a cycle, then issue new random transactions.
            for (int p = 0; p < 2; p++) begin
                if (is_ack && (t_port == 1'(p))) begin
                    pend[p] = 0; cool[p] = 1;
                    drive_port(1'(p), 0, 0, r_adr[p], r_wd[p]);
                end else if (cool[p]) begin
                    cool[p] = 0;
                end else if (!pend[p] && c < 560 && $urandom_range(2) == 0) begin
                    pend[p]  = 1;
                    r_we[p]  = 1'($urandom_range(1));
                    r_adr[p] = 32'h40 + 32'($urandom_range(15)) * 32'd4;
                    r_wd[p]  = $urandom();
                    drive_port(1'(p), 1, r_we[p], r_adr[p], r_wd[p]);
                end
            end
            // Arbitration: once the previous transaction has fully retired, grant a pending port.
            if (c >= t_start + int'(LAT) + 2 && (pend[0] || pend[1])) begin
`ifdef ARB_FIXED_PRIO_EN
                t_port = !pend[0];
`else
                t_port = (pend[0] && pend[1]) ? !m_last : pend[1];
                m_last = t_port;
`endif
                t_start = c;
                t_we  = r_we[t_port];
                t_adr = r_adr[t_port];
                t_wd  = r_wd[t_port];
                t_rd  = ref_mem[t_adr[7:2]];
                if (t_we) ref_mem[t_adr[7:2]] = t_wd;
            end
            step();
        end
        clear_inputs();
        repeat (6) step();
        n_chk++;
        begin
            int bad = 0;
            for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rand_memory: %0d words differ from model, required 0", bad);
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
        test_reset();
        test_single_read();
        test_write();
        test_contend();
        test_slow_requester();
        test_reset_abort();
        test_lat1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
